// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: ID-side inputs, EX-side outputs and stall/hold/flush of the ID/EX register.
interface id_ex_stage_reg_if #(parameter int DATA_W = 32, parameter int REG_AW = 5);
  logic              id_valid, id_regDst, id_branch, id_memRead, id_memToReg;
  logic              id_memWrite, id_alusrc, id_regWrite;
  logic [1:0]        id_aluop;
  logic [DATA_W-1:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [5:0]        id_funct;
  logic              ex_hold, flush, id_stall;
  logic              ex_valid, ex_regDst, ex_branch, ex_memRead, ex_memToReg;
  logic              ex_memWrite, ex_alusrc, ex_regWrite;
  logic [1:0]        ex_aluop;
  logic [DATA_W-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [5:0]        ex_funct;
  modport slave (
    input  id_valid, id_regDst, id_branch, id_memRead, id_memToReg, id_memWrite, id_alusrc,
           id_regWrite, id_aluop, id_pc_plus4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt,
           id_rd, id_funct, ex_hold, flush,
    output id_stall, ex_valid, ex_regDst, ex_branch, ex_memRead, ex_memToReg, ex_memWrite,
           ex_alusrc, ex_regWrite, ex_aluop, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_funct
  );
  modport master (
    output id_valid, id_regDst, id_branch, id_memRead, id_memToReg, id_memWrite, id_alusrc,
           id_regWrite, id_aluop, id_pc_plus4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt,
           id_rd, id_funct, ex_hold, flush,
    input  id_stall, ex_valid, ex_regDst, ex_branch, ex_memRead, ex_memToReg, ex_memWrite,
           ex_alusrc, ex_regWrite, ex_aluop, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_funct
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble, hold and flush.
// Optional saturating bubble/flush counters when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic clk,
  input logic rst_n,
  id_ex_stage_reg_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_flushes
`endif
);
  // control bundle: {regDst, branch, memRead, memToReg, aluop[1:0], memWrite, alusrc, regWrite}
  logic [8:0]        id_ctrl, ctrl_q, ctrl_d;
  logic              valid_q, valid_d, hazard, load, bubble;
  logic [DATA_W-1:0] pc_q, pc_d, rsd_q, rsd_d, rtd_q, rtd_d, imm_q, imm_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [5:0]        funct_q, funct_d;
  assign id_ctrl = {bus.id_regDst, bus.id_branch, bus.id_memRead, bus.id_memToReg, bus.id_aluop,
                    bus.id_memWrite, bus.id_alusrc, bus.id_regWrite};
  always_comb begin
    hazard  = bus.id_valid & valid_q & ctrl_q[6] & (rt_q != '0) &
              ((rt_q == bus.id_rs) | (rt_q == bus.id_rt));
    bubble  = ~bus.flush & ~bus.ex_hold & hazard;
    load    = ~bus.flush & ~bus.ex_hold & ~hazard;
    valid_d = bus.flush ? 1'b0 : bus.ex_hold ? valid_q : ~hazard & bus.id_valid;
    ctrl_d  = bus.flush ? '0 : bus.ex_hold ? ctrl_q : (~hazard & bus.id_valid) ? id_ctrl : '0;
    pc_d    = load ? bus.id_pc_plus4 : pc_q;
    rsd_d   = load ? bus.id_rs_data : rsd_q;
    rtd_d   = load ? bus.id_rt_data : rtd_q;
    imm_d   = load ? bus.id_imm : imm_q;
    rs_d    = load ? bus.id_rs : rs_q;
    rt_d    = load ? bus.id_rt : rt_q;
    rd_d    = load ? bus.id_rd : rd_q;
    funct_d = load ? bus.id_funct : funct_q;
  end
  // gated by rst_n so an asserted ex_hold cannot stall IF/ID while in reset
  assign bus.id_stall = rst_n & ~bus.flush & (hazard | bus.ex_hold);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      rsd_q   <= '0;
      rtd_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      funct_q <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      rsd_q   <= rsd_d;
      rtd_q   <= rtd_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      funct_q <= funct_d;
    end
  assign bus.ex_valid    = valid_q;
  assign bus.ex_regDst   = ctrl_q[8];
  assign bus.ex_branch   = ctrl_q[7];
  assign bus.ex_memRead  = ctrl_q[6];
  assign bus.ex_memToReg = ctrl_q[5];
  assign bus.ex_aluop    = ctrl_q[4:3];
  assign bus.ex_memWrite = ctrl_q[2];
  assign bus.ex_alusrc   = ctrl_q[1];
  assign bus.ex_regWrite = ctrl_q[0];
  assign bus.ex_pc_plus4 = pc_q;
  assign bus.ex_rs_data  = rsd_q;
  assign bus.ex_rt_data  = rtd_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_rs       = rs_q;
  assign bus.ex_rt       = rt_q;
  assign bus.ex_rd       = rd_q;
  assign bus.ex_funct    = funct_q;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bub_q, bub_d, fl_q, fl_d;
  always_comb begin
    bub_d = bub_q + {31'b0, bubble & ~&bub_q};
    fl_d  = fl_q + {31'b0, bus.flush & ~&fl_q};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bub_q <= '0;
      fl_q  <= '0;
    end else begin
      bub_q <= bub_d;
      fl_q  <= fl_d;
    end
  assign perf_bubbles = bub_q;
  assign perf_flushes = fl_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: table-driven vectors with a scoreboard of expected EX state.
module tb_id_ex_stage_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  id_ex_stage_reg_if #(.DATA_W(32), .REG_AW(5)) bus ();
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_bubbles, perf_flushes;
  id_ex_stage_reg #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes));
`else
  id_ex_stage_reg #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  typedef struct {
    logic v; logic [8:0] c; logic [4:0] rs, rt, rd;
    logic hold, flush, x_stall, x_v; logic [8:0] x_c; int src;
  } vec_t;
  typedef struct {
    logic v; logic [8:0] c; logic [31:0] pc, rsd, rtd, imm; logic [4:0] rs, rt, rd; logic [5:0] fn;
  } exp_t;
  vec_t tbl[18];
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0;
  int n_bad = 0;
  function automatic logic [31:0] pc_of(int j);  return 32'h1000 + 32'(4 * j); endfunction
  function automatic logic [31:0] rsd_of(int j); return (j == 0) ? 32'd5 : 32'(100 + j); endfunction
  function automatic logic [31:0] imm_of(int j); return 32'hFFFF_0000 | 32'(j); endfunction
  function automatic logic [5:0]  fn_of(int j);  return 6'(j + 32); endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask
  function automatic logic [8:0] ex_ctrl();
    return {bus.ex_regDst, bus.ex_branch, bus.ex_memRead, bus.ex_memToReg, bus.ex_aluop,
            bus.ex_memWrite, bus.ex_alusrc, bus.ex_regWrite};
  endfunction
  task automatic drive(input int i);
    {bus.id_regDst, bus.id_branch, bus.id_memRead, bus.id_memToReg, bus.id_aluop,
     bus.id_memWrite, bus.id_alusrc, bus.id_regWrite} = tbl[i].c;
    bus.id_valid    = tbl[i].v;
    bus.id_rs       = tbl[i].rs;
    bus.id_rt       = tbl[i].rt;
    bus.id_rd       = tbl[i].rd;
    bus.id_pc_plus4 = pc_of(i);
    bus.id_rs_data  = rsd_of(i);
    bus.id_rt_data  = rsd_of(i) + 32'd2;
    bus.id_imm      = imm_of(i);
    bus.id_funct    = fn_of(i);
    bus.ex_hold     = tbl[i].hold;
    bus.flush       = tbl[i].flush;
  endtask
  task automatic check_ex(input int i, input exp_t x);
    string s;
    s = $sformatf("row%0d", i);
    chk({s, " ex_valid"}, {31'b0, bus.ex_valid}, {31'b0, x.v});
    chk({s, " ex_ctrl"}, {23'b0, ex_ctrl()}, {23'b0, x.c});
    chk({s, " ex_pc_plus4"}, bus.ex_pc_plus4, x.pc);
    chk({s, " ex_rs_data"}, bus.ex_rs_data, x.rsd);
    chk({s, " ex_rt_data"}, bus.ex_rt_data, x.rtd);
    chk({s, " ex_imm"}, bus.ex_imm, x.imm);
    chk({s, " ex_idx"}, {17'b0, bus.ex_rs, bus.ex_rt, bus.ex_rd}, {17'b0, x.rs, x.rt, x.rd});
    chk({s, " ex_funct"}, {26'b0, bus.ex_funct}, {26'b0, x.fn});
  endtask
  initial begin
    // row: v, ctrl, rs, rt, rd, hold, flush | exp stall, exp valid, exp ctrl, row whose data sits in EX
    tbl[0]  = '{1'b1, 9'h111, 5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 9'h111, 0};
    tbl[1]  = '{1'b1, 9'h063, 5'd4,  5'd8,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 9'h063, 1};
    tbl[2]  = '{1'b1, 9'h111, 5'd8,  5'd9,  5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1};
    tbl[3]  = '{1'b1, 9'h111, 5'd8,  5'd9,  5'd10, 1'b0, 1'b0, 1'b0, 1'b1, 9'h111, 3};
    tbl[4]  = '{1'b1, 9'h063, 5'd1,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 9'h063, 4};
    tbl[5]  = '{1'b1, 9'h111, 5'd0,  5'd5,  5'd6,  1'b0, 1'b0, 1'b0, 1'b1, 9'h111, 5};
    tbl[6]  = '{1'b0, 9'h1FF, 5'd7,  5'd7,  5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 6};
    tbl[7]  = '{1'b1, 9'h063, 5'd2,  5'd12, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 9'h063, 7};
    tbl[8]  = '{1'b1, 9'h006, 5'd3,  5'd12, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 9'h000, 7};
    tbl[9]  = '{1'b1, 9'h063, 5'd1,  5'd13, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 9'h063, 9};
    tbl[10] = '{1'b1, 9'h111, 5'd13, 5'd4,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 9'h063, 9};
    tbl[11] = '{1'b1, 9'h111, 5'd2,  5'd3,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 9'h063, 9};
    tbl[12] = '{1'b1, 9'h111, 5'd13, 5'd4,  5'd5,  1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 9};
    tbl[13] = '{1'b1, 9'h111, 5'd13, 5'd4,  5'd5,  1'b0, 1'b0, 1'b0, 1'b1, 9'h111, 13};
    tbl[14] = '{1'b1, 9'h111, 5'd20, 5'd21, 5'd22, 1'b1, 1'b0, 1'b1, 1'b1, 9'h111, 13};
    tbl[15] = '{1'b1, 9'h111, 5'd22, 5'd23, 5'd24, 1'b0, 1'b0, 1'b0, 1'b1, 9'h111, 15};
    tbl[16] = '{1'b1, 9'h088, 5'd5,  5'd6,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 15};
    tbl[17] = '{1'b1, 9'h006, 5'd3,  5'd4,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 9'h006, 17};
    drive(0);
    bus.id_valid = 1'b0;
    bus.ex_hold  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset id_stall", {31'b0, bus.id_stall}, 32'd0);
    chk("reset ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("reset ex_ctrl", {23'b0, ex_ctrl()}, 32'd0);
    chk("reset ex_rs_data", bus.ex_rs_data, 32'd0);
    chk("reset ex_pc_plus4", bus.ex_pc_plus4, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
    chk("reset perf_bubbles", perf_bubbles, 32'd0);
    chk("reset perf_flushes", perf_flushes, 32'd0);
`endif
    @(negedge clk);
    bus.ex_hold = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(i);
      #1;
      chk($sformatf("row%0d id_stall", i), {31'b0, bus.id_stall}, {31'b0, tbl[i].x_stall});
      sb.push_back('{tbl[i].x_v, tbl[i].x_c, pc_of(tbl[i].src), rsd_of(tbl[i].src),
                     rsd_of(tbl[i].src) + 32'd2, imm_of(tbl[i].src), tbl[tbl[i].src].rs,
                     tbl[tbl[i].src].rt, tbl[tbl[i].src].rd, fn_of(tbl[i].src)});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_ex(i, e);
    end
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_bubbles", perf_bubbles, 32'd2);
    chk("perf_flushes", perf_flushes, 32'd2);
`endif
    // load enters EX, then a dependent add sits in ID; reset lands between edges
    @(negedge clk);
    drive(17);
    bus.id_valid = 1'b1;
    {bus.id_regDst, bus.id_branch, bus.id_memRead, bus.id_memToReg, bus.id_aluop,
     bus.id_memWrite, bus.id_alusrc, bus.id_regWrite} = 9'h063;
    bus.id_rt = 5'd14;
    @(posedge clk);
    @(negedge clk);
    {bus.id_regDst, bus.id_branch, bus.id_memRead, bus.id_memToReg, bus.id_aluop,
     bus.id_memWrite, bus.id_alusrc, bus.id_regWrite} = 9'h111;
    bus.id_rs = 5'd14;
    bus.id_rt = 5'd1;
    #1;
    chk("midreset pre id_stall", {31'b0, bus.id_stall}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset id_stall", {31'b0, bus.id_stall}, 32'd0);
    chk("midreset ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("midreset ex_ctrl", {23'b0, ex_ctrl()}, 32'd0);
    chk("midreset ex_rs_data", bus.ex_rs_data, 32'd0);
    chk("midreset ex_rt", {27'b0, bus.ex_rt}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
    chk("midreset perf_bubbles", perf_bubbles, 32'd0);
    chk("midreset perf_flushes", perf_flushes, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
